// File: rtl/paddle_up_mover.sv
// Paddle up-move engine: owns the paddle y position and streams erase/redraw
// pixels into the VGA plot port, one STEP upward per accepted frame tick.
module paddle_up_mover #(
    parameter int unsigned STEP    = 10,
    parameter int unsigned Y_MIN   = 0,
    parameter int unsigned Y_RESET = 100,
    parameter int unsigned PAD_W   = 10,
    parameter int unsigned PAD_H   = 40,
    parameter int unsigned X_LEFT  = 0,
    parameter int unsigned X_RIGHT = 310
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       player,
    input  logic       up_req,
    input  logic       tick,
    input  logic       ld_y,
    input  logic [7:0] y_in,
    output logic       plot,
    output logic [8:0] x_out,
    output logic [7:0] y_out,
    output logic [2:0] colour,
    output logic [7:0] paddle_y,
    output logic       at_top,
    output logic       busy
);

    localparam int unsigned XW = 9;
    localparam int unsigned YW = 8;
    localparam logic [XW-1:0] DX_LAST   = XW'(PAD_W - 1);
    localparam logic [YW-1:0] DY_LAST   = YW'(PAD_H - 1);
    localparam logic [YW-1:0] Y_MIN_V   = YW'(Y_MIN);
    localparam logic [YW-1:0] Y_RESET_V = YW'(Y_RESET);
    localparam logic [YW-1:0] STEP_V    = YW'(STEP);
    localparam logic [YW-1:0] Y_SAT     = YW'(Y_MIN + STEP);
    localparam logic [XW-1:0] XL_V      = XW'(X_LEFT);
    localparam logic [XW-1:0] XR_V      = XW'(X_RIGHT);

    typedef enum logic [2:0] {INIT, IDLE, ERASE, UPDATE, DRAW} state_t;

    state_t        state, state_n;
    logic [XW-1:0] dx, dx_n, adv_dx, base_x;
    logic [YW-1:0] dy, dy_n, adv_dy;
    logic [YW-1:0] py_n;
    logic          pix_last;
    logic          drawing_n;

    // Counters hold the pixel shown in the current cycle; outputs are
    // registered from the next-cycle values so plot lines up with the state.
    always_comb begin
        state_n  = state;
        dx_n     = dx;
        dy_n     = dy;
        py_n     = paddle_y;
        base_x   = player ? XR_V : XL_V;
        pix_last = (dx == DX_LAST) && (dy == DY_LAST);
        adv_dx   = (dx == DX_LAST) ? '0 : dx + XW'(1);
        adv_dy   = (dx == DX_LAST) ? dy + YW'(1) : dy;

        case (state)
            INIT: begin
                // plot is low only on the first INIT cycle after reset:
                // pixel 0 has not been shown yet, so hold the counters.
                if (plot) begin
                    if (pix_last) begin
                        state_n = IDLE;
                        dx_n    = '0;
                        dy_n    = '0;
                    end else begin
                        dx_n = adv_dx;
                        dy_n = adv_dy;
                    end
                end
            end
            IDLE: begin
                if (ld_y) begin
                    py_n = y_in;
                end else if (tick && up_req && (paddle_y > Y_MIN_V)) begin
                    state_n = ERASE;
                    dx_n    = '0;
                    dy_n    = '0;
                end
            end
            ERASE: begin
                if (pix_last) begin
                    state_n = UPDATE;
                    dx_n    = '0;
                    dy_n    = '0;
                end else begin
                    dx_n = adv_dx;
                    dy_n = adv_dy;
                end
            end
            UPDATE: begin
                state_n = DRAW;
                dx_n    = '0;
                dy_n    = '0;
                py_n    = (paddle_y >= Y_SAT) ? paddle_y - STEP_V : Y_MIN_V;
            end
            DRAW: begin
                if (pix_last) begin
                    state_n = IDLE;
                    dx_n    = '0;
                    dy_n    = '0;
                end else begin
                    dx_n = adv_dx;
                    dy_n = adv_dy;
                end
            end
            default: begin
                state_n = INIT;
                dx_n    = '0;
                dy_n    = '0;
            end
        endcase

        drawing_n = (state_n == INIT) || (state_n == ERASE) || (state_n == DRAW);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= INIT;
            dx       <= '0;
            dy       <= '0;
            paddle_y <= Y_RESET_V;
            plot     <= 1'b0;
            x_out    <= '0;
            y_out    <= '0;
            colour   <= 3'b000;
            busy     <= 1'b1;
            at_top   <= (Y_RESET_V == Y_MIN_V);
        end else begin
            state    <= state_n;
            dx       <= dx_n;
            dy       <= dy_n;
            paddle_y <= py_n;
            plot     <= drawing_n;
            x_out    <= drawing_n ? base_x + dx_n : '0;
            y_out    <= drawing_n ? py_n + dy_n : '0;
            colour   <= (drawing_n && (state_n != ERASE)) ? 3'b111 : 3'b000;
            busy     <= (state_n != IDLE);
            at_top   <= (py_n == Y_MIN_V);
        end
    end

endmodule

// File: tb/tb_paddle_up_mover.sv
// Self-checking bench for paddle_up_mover: a pixel-stream model expands each
// accepted operation into its expected per-cycle output records.
module tb_paddle_up_mover;

    localparam int W = 10;
    localparam int H = 40;

    typedef struct packed {
        logic       plot;
        logic [8:0] x;
        logic [7:0] y;
        logic [2:0] col;
        logic       busy;
        logic [7:0] py;
    } rec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       player = 1'b0;
    logic       up_req = 1'b0;
    logic       tick = 1'b0;
    logic       ld_y = 1'b0;
    logic [7:0] y_in = 8'd0;
    logic       plot;
    logic [8:0] x_out;
    logic [7:0] y_out;
    logic [2:0] colour;
    logic [7:0] paddle_y;
    logic       at_top;
    logic       busy;

    paddle_up_mover dut (
        .clk(clk), .reset(reset), .player(player), .up_req(up_req),
        .tick(tick), .ld_y(ld_y), .y_in(y_in), .plot(plot), .x_out(x_out),
        .y_out(y_out), .colour(colour), .paddle_y(paddle_y), .at_top(at_top),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    rec_t q[$];
    bit   init_pend = 1'b0;
    int   m_py = 100;

    int plot_cnt, busy_cnt, er_cnt, dr_cnt;
    int first_x, first_y, last_x, last_y;
    int dr_first_x, dr_first_y, dr_last_x, dr_last_y;
    bit seen, dseen;

    task automatic clr_stats();
        plot_cnt = 0; busy_cnt = 0; er_cnt = 0; dr_cnt = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        dr_first_x = -1; dr_first_y = -1; dr_last_x = -1; dr_last_y = -1;
        seen = 1'b0; dseen = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int base_x();
        return player ? 310 : 0;
    endfunction

    task automatic push_pix(input int bx, input int py, input logic [2:0] col);
        for (int dy = 0; dy < H; dy++)
            for (int dx = 0; dx < W; dx++)
                q.push_back({1'b1, 9'(bx + dx), 8'(py + dy), col, 1'b1, 8'(py)});
    endtask

    // Expected outputs for the cycle following the edge at which the current inputs are sampled.
    task automatic model_edge(output rec_t e);
        int old;
        if (reset) begin
            q.delete();
            init_pend = 1'b1;
            m_py = 100;
            e = {1'b0, 9'd0, 8'd0, 3'd0, 1'b1, 8'd100};
            return;
        end
        if (init_pend) begin
            init_pend = 1'b0;
            push_pix(base_x(), m_py, 3'b111);
        end else if (q.size() == 0) begin
            if (ld_y) begin
                m_py = int'(y_in);
            end else if (tick && up_req && m_py > 0) begin
                old  = m_py;
                m_py = (m_py >= 10) ? m_py - 10 : 0;
                push_pix(base_x(), old, 3'b000);
                q.push_back({1'b0, 9'd0, 8'd0, 3'd0, 1'b1, 8'(old)});
                push_pix(base_x(), m_py, 3'b111);
            end
        end
        if (q.size() > 0) e = q.pop_front();
        else              e = {1'b0, 9'd0, 8'd0, 3'd0, 1'b0, 8'(m_py)};
    endtask

    // Single compare point: advance one edge, then check every output.
    task automatic step();
        rec_t e, a;
        @(posedge clk);
        model_edge(e);
        #1;
        cyc++;
        a = {plot, x_out, y_out, colour, busy, paddle_y};
        checks++;
        if (a !== e || at_top !== (e.py == 8'd0)) begin
            errors++;
            if (errors < 20)
                $display("FAIL cycle %0d outputs: got plot=%b x=%0d y=%0d col=%0d busy=%b py=%0d top=%b expected plot=%b x=%0d y=%0d col=%0d busy=%b py=%0d top=%b",
                         cyc, plot, x_out, y_out, colour, busy, paddle_y, at_top,
                         e.plot, e.x, e.y, e.col, e.busy, e.py, (e.py == 8'd0));
        end
        if (plot === 1'b1) begin
            plot_cnt++;
            if (!seen) begin first_x = int'(x_out); first_y = int'(y_out); seen = 1'b1; end
            last_x = int'(x_out); last_y = int'(y_out);
            if (colour == 3'b000) er_cnt++;
            else begin
                dr_cnt++;
                if (!dseen) begin dr_first_x = int'(x_out); dr_first_y = int'(y_out); dseen = 1'b1; end
                dr_last_x = int'(x_out); dr_last_y = int'(y_out);
            end
        end
        if (busy === 1'b1) busy_cnt++;
    endtask

    task automatic run_idle();
        while (q.size() > 0 || init_pend) step();
    endtask

    task automatic pulse_tick();
        tick = 1'b1; step(); tick = 1'b0;
    endtask

    task automatic load(input logic [7:0] v);
        ld_y = 1'b1; y_in = v; step(); ld_y = 1'b0;
    endtask

    initial begin
        clr_stats();
        // Reset and initial draw on the left paddle
        repeat (3) step();
        reset = 1'b0;
        clr_stats();
        run_idle();
        step();
        chk("init_plot_count", plot_cnt, 400);
        chk("init_first_x", first_x, 0);
        chk("init_first_y", first_y, 100);
        chk("init_last_x", last_x, 9);
        chk("init_last_y", last_y, 139);
        chk("init_busy_after", int'(busy), 0);
        chk("init_paddle_y", int'(paddle_y), 100);

        // One accepted tick from 100
        up_req = 1'b1;
        clr_stats();
        pulse_tick();
        run_idle();
        step();
        chk("move_erase_count", er_cnt, 400);
        chk("move_erase_first_y", first_y, 100);
        chk("move_draw_count", dr_cnt, 400);
        chk("move_draw_first_y", dr_first_y, 90);
        chk("move_draw_last_x", dr_last_x, 9);
        chk("move_draw_last_y", dr_last_y, 129);
        chk("move_busy_cycles", busy_cnt, 801);
        chk("move_paddle_y", int'(paddle_y), 90);

        // Saturating move on the right paddle
        player = 1'b1;
        load(8'd4);
        chk("load_paddle_y", int'(paddle_y), 4);
        clr_stats();
        pulse_tick();
        run_idle();
        step();
        chk("sat_paddle_y", int'(paddle_y), 0);
        chk("sat_at_top", int'(at_top), 1);
        chk("sat_draw_first_x", dr_first_x, 310);
        chk("sat_draw_last_x", dr_last_x, 319);
        chk("sat_draw_last_y", dr_last_y, 39);
        clr_stats();
        pulse_tick();
        repeat (5) step();
        chk("top_tick_plots", plot_cnt, 0);
        chk("top_tick_busy", busy_cnt, 0);

        // Tick without up_req, and ticks/loads while busy
        load(8'd120);
        up_req = 1'b0;
        clr_stats();
        pulse_tick();
        repeat (3) step();
        chk("noreq_plots", plot_cnt, 0);
        chk("noreq_paddle_y", int'(paddle_y), 120);
        up_req = 1'b1;
        pulse_tick();
        repeat (50) step();
        pulse_tick();
        ld_y = 1'b1; y_in = 8'd200; step(); ld_y = 1'b0;
        repeat (400) step();
        pulse_tick();
        run_idle();
        step();
        chk("busy_ignore_paddle_y", int'(paddle_y), 110);

        // Load and tick in the same idle cycle
        clr_stats();
        ld_y = 1'b1; tick = 1'b1; y_in = 8'd50; step();
        ld_y = 1'b0; tick = 1'b0;
        repeat (3) step();
        chk("ld_tick_paddle_y", int'(paddle_y), 50);
        chk("ld_tick_plots", plot_cnt, 0);

        // Reset in the middle of an erase
        player = 1'b0;
        pulse_tick();
        repeat (199) step();
        reset = 1'b1; step();
        chk("midreset_plot", int'(plot), 0);
        reset = 1'b0;
        clr_stats();
        run_idle();
        step();
        chk("reinit_count", plot_cnt, 400);
        chk("reinit_first_y", first_y, 100);
        chk("reinit_last_y", last_y, 139);
        chk("reinit_paddle_y", int'(paddle_y), 100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/paddle_up_mover.md
# paddle_up_mover

Moves one player's paddle upward on the 320x240 VGA playfield, one step per frame tick while the up button is held. It owns the paddle's y position and emits a pixel stream (erase old paddle, then redraw at the new position) into the shared VGA plot port. It is the up-direction counterpart of the paddle down-move logic and sits between the player input synchroniser and the VGA adapter arbiter.

## Interface
Parameters:
- STEP, 10: pixels moved per accepted tick
- Y_MIN, 0: topmost legal paddle y (top edge of paddle)
- Y_RESET, 100: paddle y after reset
- PAD_W, 10: paddle width in pixels
- PAD_H, 40: paddle height in pixels
- X_LEFT, 0: paddle x when player = 0
- X_RIGHT, 310: paddle x when player = 1

Ports:
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- player  in  1  0 = left paddle (X_LEFT), 1 = right paddle (X_RIGHT); static during operation
- up_req  in  1  level, up button held (already synchronised)
- tick  in  1  one-cycle frame pulse
- ld_y  in  1  load paddle_y from y_in (used when the down mover changes position)
- y_in  in  8  position to load
- plot  out  1  pixel valid this cycle
- x_out  out  9  pixel x
- y_out  out  8  pixel y
- colour  out  3  pixel colour: 3'b000 erase, 3'b111 draw
- paddle_y  out  8  current paddle top y
- at_top  out  1  paddle_y == Y_MIN
- busy  out  1  high in every state except IDLE

## Operation
- States: INIT, IDLE, ERASE, UPDATE, DRAW.
- Reset: state=INIT, paddle_y=Y_RESET, pixel counters=0, plot=0, x_out=0, y_out=0, colour=0, busy=1. at_top follows paddle_y.
- INIT: draws the paddle at Y_RESET (PAD_W*PAD_H pixels, colour 3'b111), then goes to IDLE.
- IDLE: plot=0.
  - If ld_y=1, paddle_y<=y_in; tick ignored that cycle; no redraw.
  - Else if tick=1, up_req=1 and paddle_y>Y_MIN, go to ERASE.
  - Otherwise stay in IDLE. A tick with up_req=0 or at_top=1 does nothing.
- ERASE: plots every paddle pixel at the old paddle_y with colour 3'b000.
- UPDATE: one cycle, plot=0.
  - paddle_y<=paddle_y-STEP if paddle_y>=Y_MIN+STEP, else Y_MIN (saturate; never wraps).
- DRAW: plots every paddle pixel at the new paddle_y with colour 3'b111, then goes to IDLE.
- Pixel order (INIT/ERASE/DRAW): row-major. Inner loop dx 0..PAD_W-1, outer loop dy 0..PAD_H-1.
  - x_out = base_x+dx, y_out = paddle_y+dy, where base_x = X_RIGHT if player else X_LEFT.
- Arithmetic: 9-bit x, 8-bit y. Parameters must keep every pixel on screen (base_x+PAD_W<=320, Y_RESET+PAD_H<=240), so there is no overflow.
- tick, ld_y and up_req are ignored outside IDLE. Ticks are dropped, not queued.

## Timing
- All outputs are registered.
- N = PAD_W*PAD_H (400 with defaults).
- After reset is released (first edge with reset low at cycle R):
  - plot=1 for cycles R+1..R+N (INIT).
  - IDLE and busy=0 from cycle R+N+1.
- Accepted tick sampled at edge T:
  - ERASE plot=1 for cycles T+1..T+N.
  - UPDATE at cycle T+N+1: plot=0, new paddle_y visible from T+N+2.
  - DRAW plot=1 for cycles T+N+2..T+2N+1.
  - IDLE and busy=0 at T+2N+2.
- busy is high for exactly the cycles in which the block is not IDLE.
- Earliest next accepted tick: edge T+2N+2.
- Reset mid-operation: on the next edge the block enters INIT with paddle_y=Y_RESET and plot=0 during the reset cycle. The partial erase or draw is abandoned.
- ld_y and tick in the same IDLE cycle: the load wins and the tick is lost.

## Test plan
- Reset, player=0: exactly 400 plot pulses; first pixel (0,100), last (9,139), colour 7; then busy=0, paddle_y=100.
- Hold up_req=1, one tick from paddle_y=100:
  - 400 erase pixels colour 0 spanning (0..9,100..139).
  - One gap cycle.
  - 400 draw pixels colour 7 spanning (0..9,90..129).
  - paddle_y=90; busy high for 801 cycles.
- ld_y with y_in=4, then tick with up_req=1, player=1: paddle_y saturates to 0 and at_top=1; draw x range 310..319. A further tick produces no plot and busy stays 0.
- Tick with up_req=0, and a tick asserted while busy: no state change, no plot, paddle_y unchanged.
- ld_y=1 and tick=1 in the same IDLE cycle with y_in=50: paddle_y=50, no plot.
- Reset asserted at cycle 200 of ERASE: plot=0 on the following cycle. INIT redraws at y 100..139, and paddle_y=100.
